// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, instruction field positions and
// the fetch sequencer state encoding. Used by fetch and the control unit.
package cpu_pkg;

    localparam int INSTR_W       = 32;
    localparam int OPC_MSB       = 31;
    localparam int OPC_LSB       = 28;
    localparam int IMM_W_DEFAULT = 24;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_B   = 4'b0001,
        OP_BEQ = 4'b0010,
        OP_BLT = 4'b0011,
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0101,
        OP_AND = 4'b0110,
        OP_OR  = 4'b0111,
        OP_XOR = 4'b1000,
        OP_LD  = 4'b1001,
        OP_ST  = 4'b1010,
        OP_SHR = 4'b1011,
        OP_SHL = 4'b1100
    } opcode_e;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_BRWAIT = 2'd2
    } fetch_state_e;

    // Encodings above OP_SHL have no defined instruction.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > 4'(OP_SHL);
    endfunction

endpackage

// File: rtl/fetch_sequencer_branch_resolve.sv
// branch_resolve: combinational branch decision and target generation.
// Offset is a signed word offset, so it is sign-extended and scaled by 4.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int IMM_W = IMM_W_DEFAULT
) (
    input  logic [3:0]       opcode,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic [31:0]      pc,
    input  logic [IMM_W-1:0] offset,
    output logic             taken,
    output logic [31:0]      target
);

    logic [31:0] off_ext;

    assign off_ext = {{(32-IMM_W){offset[IMM_W-1]}}, offset};

    // Decide taken from opcode and flags; target wraps mod 2^32.
    always_comb begin
        taken  = (opcode == OP_B)
               | ((opcode == OP_BEQ) & flag_z)
               | ((opcode == OP_BLT) & flag_n);
        target = pc + (off_ext << 2);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch front end.
// Fetches a word, holds it for decode, and stalls on branches until execute
// returns the compare flags.
// Optional build macro FETCH_ILLEGAL_TRAP_EN: opcodes above OP_SHL are replaced
// by a NOP and a sticky illegal flag is raised; without it they pass through.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMM_W    = IMM_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [3:0]  opcode,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    input  logic        branch_select,
    input  logic        resolve_valid,
    input  logic        flag_z,
    input  logic        flag_n,
    output logic        illegal
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         req_q, req_d;
    logic         br_taken;
    logic [31:0]  br_target;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic         illegal_q, illegal_d;
`endif

    // Branch decision always looks at the held branch and its own address.
    branch_resolve #(
        .IMM_W (IMM_W)
    ) u_branch_resolve (
        .opcode (instr_q[OPC_MSB:OPC_LSB]),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .pc     (instr_pc_q),
        .offset (instr_q[IMM_W-1:0]),
        .taken  (br_taken),
        .target (br_target)
    );

    // Next-state logic; req is registered so it is low in the cycle after reset.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        req_d         = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif
        case (state_q)
            S_REQ: begin
                req_d = 1'b1;
                if (req_q && imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    req_d         = 1'b0;
                    state_d       = S_HOLD;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    if (is_illegal_op(imem_rdata[OPC_MSB:OPC_LSB])) begin
                        instr_d   = '0;
                        illegal_d = 1'b1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (instr_valid_q && decode_ready) begin
                    instr_valid_d = 1'b0;
                    if (branch_select) begin
                        state_d = S_BRWAIT;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_BRWAIT: begin
                instr_valid_d = 1'b0;
                if (resolve_valid) begin
                    pc_d    = br_taken ? br_target : instr_pc_q + 32'd4;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            req_q         <= req_d;
        end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch front end. Generates word addresses to instruction memory, holds each fetched word, and presents its 4-bit opcode to the control unit through a valid/ready handshake.
- Resolves branches 0001/0010/0011 by stalling issue until execute returns the compare flags, then redirects the PC.
- Sits between instruction memory and decode. It is the producer side of the opcode/branch-select interface.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMM_W, 24, width of the branch offset field instr[IMM_W-1:0], a signed word offset.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  byte address, always word aligned
- imem_ready  in  1  memory accepts the request and returns rdata in the same cycle
- imem_rdata  in  32  instruction word
- instr  out  32  held instruction
- opcode  out  4  instr[31:28], drives control-unit OpCode
- instr_pc  out  32  address of the held instruction
- instr_valid  out  1  instr/opcode valid
- decode_ready  in  1  decode accepts the instruction
- branch_select  in  1  control-unit BranchSelect for the presented opcode
- resolve_valid  in  1  execute has the branch compare result
- flag_z  in  1  zero flag, sampled only with resolve_valid
- flag_n  in  1  negative flag, sampled only with resolve_valid
- illegal  out  1  sticky illegal-opcode flag; constant 0 unless the optional feature is compiled in

Behaviour:
- Reset (synchronous, rst=1 at an edge), from any state including mid-fetch or mid-branch:
  - pc=RESET_PC, state=S_REQ.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, illegal=0.
  - Any pending resolve is discarded.
- States: S_REQ, S_HOLD, S_BRWAIT.
- S_REQ:
  - Drive imem_req=1 and imem_addr=pc.
  - On imem_ready: latch instr=imem_rdata and instr_pc=pc; set instr_valid=1 next cycle; go to S_HOLD.
  - Fetch latency is 1 cycle after imem_ready.
- S_HOLD:
  - imem_req=0. instr, opcode and instr_valid stay stable until decode_ready=1.
  - On a transfer (instr_valid & decode_ready), clear instr_valid next cycle.
  - If branch_select=0: pc = pc+4, go to S_REQ.
  - If branch_select=1: go to S_BRWAIT and keep the branch PC and offset.
- S_BRWAIT:
  - imem_req=0, instr_valid=0. Wait for resolve_valid.
  - taken = (op==0001) | (op==0010 & flag_z) | (op==0011 & flag_n).
  - taken: pc = instr_pc + (sign_extend(instr[IMM_W-1:0]) << 2), computed mod 2^32.
  - not taken: pc = instr_pc+4.
  - Then go to S_REQ. Redirect penalty: the fetch issues the cycle after resolve_valid.
- Any resolve_valid seen outside S_BRWAIT is ignored.
- The PC wraps from 32'hFFFF_FFFC to 0 with no error.
- NOP (0000) is issued like any other non-branch.
- Opcodes 1101–1111 are passed through unchanged. illegal stays 0.
- At most one instruction is in flight. There is no prefetch.
- imem_ready and decode_ready are ignored in states where they have no meaning.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- When defined:
  - An opcode 1101–1111 latched in S_REQ is replaced by instr=32'h0 (NOP), and illegal is set.
  - illegal is sticky until rst.
  - instr_pc still reports the real address.
  - The sequence continues with pc+4.
- When undefined: raw passthrough, and illegal is tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode enum (OP_NOP..OP_SHL, values 0000–1100)
  - OPC_MSB=31, OPC_LSB=28, IMM_W default, INSTR_W=32
  - the fetch state enum
- The control unit uses the same opcode constants.
- One natural sub-module: branch_resolve. It is combinational: opcode, flags, pc and offset in; taken and target out.

Test Plan:
- Reset, imem_ready=1 always, decode_ready=1, stream of ADD words → addresses 0,4,8,C; each instr_valid one cycle after imem_ready.
- decode_ready held 0 for 5 cycles on a word at 0x8 → instr and opcode stable, no new imem_req, pc advances to 0xC only after the transfer.
- BEQ at 0x10 with offset 24'hFFFFFE, resolve_valid with flag_z=1 → next imem_addr=0x08. Repeat with flag_z=0 → next imem_addr=0x14.
- BLT at 0x20 with offset 3 and flag_n=1 → 0x2C. Unconditional B with flags 0 → still taken.
- rst asserted during S_BRWAIT with resolve_valid also high → next cycle imem_addr=RESET_PC, instr_valid=0, no redirect applied.
- FETCH_ILLEGAL_TRAP_EN defined, word 32'hE000_0000 at 0x4 → opcode=0000, illegal=1 and held, next fetch at 0x8. Undefined → opcode=1110, illegal=0.
